// File: rtl/ps2_mouse_pkg.sv
// Shared definitions for the PS/2 mouse tracker: packet states, status-byte
// field positions, default geometry/timeout and small arithmetic helpers.
package ps2_mouse_pkg;

    typedef enum logic [1:0] {
        P_B0 = 2'd0,
        P_B1 = 2'd1,
        P_B2 = 2'd2
    } pkt_state_t;

    localparam int ST_L    = 0;
    localparam int ST_R    = 1;
    localparam int ST_M    = 2;
    localparam int ST_SYNC = 3;
    localparam int ST_XS   = 4;
    localparam int ST_YS   = 5;
    localparam int ST_XO   = 6;
    localparam int ST_YO   = 7;

    localparam int DEF_H_RES          = 640;
    localparam int DEF_V_RES          = 480;
    localparam int DEF_TIMEOUT_CYCLES = 200000;

    // PS/2 uses odd parity over data plus parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    function automatic logic [15:0] clamp_axis(input logic signed [16:0] v,
                                               input logic [15:0]        res);
        logic signed [16:0] max_v;
        max_v = $signed({1'b0, res - 16'd1});
        if (v < 17'sd0) begin
            return 16'd0;
        end else if (v > max_v) begin
            return res - 16'd1;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 device-to-host byte receiver: synchronizers, falling-edge sampling,
// 11-bit frame check and idle timeout. Optional clock glitch filter: PS2_CLK_FILTER_EN.
module ps2_rx_byte
    import ps2_mouse_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    input  logic       i_busy,
    output logic       o_byte_valid,
    output logic       o_byte_err,
    output logic [7:0] o_byte,
    output logic       o_abort
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic          r_clk_s1;
    logic          r_clk_s2;
    logic          r_dat_s1;
    logic          r_dat_s2;
    logic          r_clk_prev;
    logic [9:0]    r_shift;
    logic [3:0]    r_bitcnt;
    logic [CW-1:0] r_idle;
    logic          w_clk_use;
    logic          w_fall;
    logic          w_frame_ok;
    logic [10:0]   w_frame;

    // Two-flop synchronizers; the PS/2 lines idle high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

`ifdef PS2_CLK_FILTER_EN
    logic [7:0] r_filt_sh;
    logic       r_clk_filt;

    // Filtered clock only moves once eight consecutive samples agree.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_filt_sh  <= 8'hFF;
            r_clk_filt <= 1'b1;
        end else begin
            r_filt_sh <= {r_filt_sh[6:0], r_clk_s2};
            if (&r_filt_sh) begin
                r_clk_filt <= 1'b1;
            end else if (~|r_filt_sh) begin
                r_clk_filt <= 1'b0;
            end
        end
    end

    assign w_clk_use = r_clk_filt;
`else
    assign w_clk_use = r_clk_s2;
`endif

    // Edge detect and frame assembly; the current data bit completes the frame.
    always_comb begin
        w_fall     = r_clk_prev & ~w_clk_use;
        w_frame    = {r_dat_s2, r_shift};
        w_frame_ok = ~w_frame[0] & w_frame[10] & odd_parity_ok(w_frame[8:1], w_frame[9]);
    end

    // Bit shifter, byte strobes and idle timeout.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_prev   <= 1'b1;
            r_shift      <= 10'd0;
            r_bitcnt     <= 4'd0;
            r_idle       <= {CW{1'b0}};
            o_byte_valid <= 1'b0;
            o_byte_err   <= 1'b0;
            o_byte       <= 8'd0;
            o_abort      <= 1'b0;
        end else begin
            r_clk_prev   <= w_clk_use;
            o_byte_valid <= 1'b0;
            o_byte_err   <= 1'b0;
            o_abort      <= 1'b0;
            if (w_fall) begin
                r_idle  <= {CW{1'b0}};
                r_shift <= {r_dat_s2, r_shift[9:1]};
                if (r_bitcnt == 4'd10) begin
                    r_bitcnt     <= 4'd0;
                    o_byte       <= w_frame[8:1];
                    o_byte_valid <= w_frame_ok;
                    o_byte_err   <= ~w_frame_ok;
                end else begin
                    r_bitcnt <= r_bitcnt + 4'd1;
                end
            end else if (r_idle == CW'(TIMEOUT_CYCLES)) begin
                // Saturated: abort once if anything is still partial.
                if ((r_bitcnt != 4'd0) || (i_busy && !o_abort)) begin
                    r_bitcnt <= 4'd0;
                    o_abort  <= 1'b1;
                end
            end else begin
                r_idle <= r_idle + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse packet decoder and clamped absolute cursor accumulator.
// Optional ps2_clk glitch filter in the receiver: PS2_CLK_FILTER_EN.
module ps2_mouse_tracker
    import ps2_mouse_pkg::*;
#(
    parameter int H_RES          = DEF_H_RES,
    parameter int V_RES          = DEF_V_RES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] mouse_position_x,
    output logic [15:0] mouse_position_y,
    output logic [2:0]  mouse_buttons,
    output logic        packet_valid,
    output logic        frame_err
);

    pkt_state_t         r_state;
    logic [2:0]         r_btn_pend;
    logic               r_xs;
    logic               r_ys;
    logic               r_xo;
    logic               r_yo;
    logic [7:0]         r_dx;
    logic [15:0]        r_x;
    logic [15:0]        r_y;
    logic [2:0]         r_buttons;
    logic               r_pv;
    logic               r_fe;

    logic               w_byte_valid;
    logic               w_byte_err;
    logic [7:0]         w_byte;
    logic               w_abort;
    logic               w_busy;
    logic signed [16:0] w_dx;
    logic signed [16:0] w_dy;
    logic signed [16:0] w_nx;
    logic signed [16:0] w_ny;
    logic [15:0]        w_nx_c;
    logic [15:0]        w_ny_c;

    assign w_busy = (r_state != P_B0);

    ps2_rx_byte #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .i_clk        (clk),
        .i_rst        (rstn),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .i_busy       (w_busy),
        .o_byte_valid (w_byte_valid),
        .o_byte_err   (w_byte_err),
        .o_byte       (w_byte),
        .o_abort      (w_abort)
    );

    // Next position: current byte is dy while in P_B2; PS/2 +Y points up.
    always_comb begin
        w_dx   = r_xo ? 17'sd0 : $signed({{8{r_xs}}, r_xs, r_dx});
        w_dy   = r_yo ? 17'sd0 : $signed({{8{r_ys}}, r_ys, w_byte});
        w_nx   = $signed({1'b0, r_x}) + w_dx;
        w_ny   = $signed({1'b0, r_y}) - w_dy;
        w_nx_c = clamp_axis(w_nx, 16'(H_RES));
        w_ny_c = clamp_axis(w_ny, 16'(V_RES));
    end

    // Packet state machine with registered position, buttons and strobes.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state    <= P_B0;
            r_btn_pend <= 3'd0;
            r_xs       <= 1'b0;
            r_ys       <= 1'b0;
            r_xo       <= 1'b0;
            r_yo       <= 1'b0;
            r_dx       <= 8'd0;
            r_x        <= 16'(H_RES / 2);
            r_y        <= 16'(V_RES / 2);
            r_buttons  <= 3'd0;
            r_pv       <= 1'b0;
            r_fe       <= 1'b0;
        end else begin
            r_pv <= 1'b0;
            r_fe <= 1'b0;
            if (w_abort) begin
                r_state <= P_B0;
            end else if (w_byte_err) begin
                r_state <= P_B0;
                r_fe    <= 1'b1;
            end else if (w_byte_valid) begin
                case (r_state)
                    P_B0: begin
                        if (w_byte[ST_SYNC]) begin
                            r_btn_pend <= {w_byte[ST_M], w_byte[ST_R], w_byte[ST_L]};
                            r_xs       <= w_byte[ST_XS];
                            r_ys       <= w_byte[ST_YS];
                            r_xo       <= w_byte[ST_XO];
                            r_yo       <= w_byte[ST_YO];
                            r_state    <= P_B1;
                        end else begin
                            r_fe <= 1'b1;
                        end
                    end
                    P_B1: begin
                        r_dx    <= w_byte;
                        r_state <= P_B2;
                    end
                    P_B2: begin
                        r_x       <= w_nx_c;
                        r_y       <= w_ny_c;
                        r_buttons <= r_btn_pend;
                        r_pv      <= 1'b1;
                        r_state   <= P_B0;
                    end
                    default: begin
                        r_state <= P_B0;
                    end
                endcase
            end
        end
    end

    assign mouse_position_x = r_x;
    assign mouse_position_y = r_y;
    assign mouse_buttons    = r_buttons;
    assign packet_valid     = r_pv;
    assign frame_err        = r_fe;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Directed bench for ps2_mouse_tracker: bit-banged PS/2 packets, hand-computed positions.
module tb_ps2_mouse_tracker;

    localparam int HALF = 16;
    localparam int GAP  = 50;
    localparam int TMO  = 2000;

    logic        clk;
    logic        rstn;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] mouse_position_x;
    logic [15:0] mouse_position_y;
    logic [2:0]  mouse_buttons;
    logic        packet_valid;
    logic        frame_err;

    int n_cmp;
    int n_err;
    int pv_cnt;
    int fe_cnt;
    int pv0;
    int fe0;

    ps2_mouse_tracker #(
        .H_RES          (640),
        .V_RES          (480),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .ps2_clk          (ps2_clk),
        .ps2_data         (ps2_data),
        .mouse_position_x (mouse_position_x),
        .mouse_position_y (mouse_position_y),
        .mouse_buttons    (mouse_buttons),
        .packet_valid     (packet_valid),
        .frame_err        (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count high cycles of each strobe so a stuck or doubled pulse shows up.
    always @(negedge clk) begin
        if (packet_valid) pv_cnt <= pv_cnt + 1;
        if (frame_err)    fe_cnt <= fe_cnt + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_frame(d, 1'b0, 11);
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
    endtask

    task automatic check_pos(input string tag, input int ex, input int ey, input int eb);
        check({tag, ".x"}, int'(mouse_position_x), ex);
        check({tag, ".y"}, int'(mouse_position_y), ey);
        check({tag, ".btn"}, int'(mouse_buttons), eb);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; pv_cnt = 0; fe_cnt = 0;
        ps2_clk = 1'b1; ps2_data = 1'b1; rstn = 1'b1;
        repeat (5) @(negedge clk);
        check_pos("reset", 320, 240, 0);
        check("reset.pv", int'(packet_valid), 0);
        check("reset.fe", int'(frame_err), 0);
        rstn = 1'b0;
        repeat (5) @(negedge clk);

        // Basic packet
        pv0 = pv_cnt; fe0 = fe_cnt;
        send_packet(8'h08, 8'h05, 8'h03);
        check_pos("t1", 325, 237, 0);
        check("t1.pv_pulses", pv_cnt - pv0, 1);

        // Negative X, left button
        send_packet(8'h19, 8'hFB, 8'h00);
        check_pos("t2", 320, 237, 1);

        // Right-edge clamp, then large negative deltas on both axes
        for (int i = 0; i < 6; i++) send_packet(8'h08, 8'h7F, 8'h00);
        check_pos("t3.clamp", 639, 237, 0);
        send_packet(8'h38, 8'h80, 8'h80);
        check_pos("t3.neg", 511, 365, 0);
        check("t3.fe_none", fe_cnt - fe0, 0);

        // Bad parity mid-packet, then an unsynced byte, then a clean packet
        pv0 = pv_cnt; fe0 = fe_cnt;
        send_byte(8'h08);
        send_frame(8'h01, 1'b1, 11);
        check("t4.fe_parity", fe_cnt - fe0, 1);
        check("t4.x_hold", int'(mouse_position_x), 511);
        send_byte(8'h00);
        check("t4.fe_resync", fe_cnt - fe0, 2);
        send_packet(8'h08, 8'h01, 8'h00);
        check_pos("t4.after", 512, 365, 0);
        check("t4.pv_pulses", pv_cnt - pv0, 1);

        // Timeouts: partial byte, then partial packet
        fe0 = fe_cnt;
        send_frame(8'h08, 1'b0, 5);
        repeat (TMO + 200) @(negedge clk);
        send_packet(8'h08, 8'h02, 8'h00);
        check("t5.bit_tmo", int'(mouse_position_x), 514);
        send_byte(8'h08);
        repeat (TMO + 200) @(negedge clk);
        send_packet(8'h08, 8'h02, 8'h00);
        check("t5.pkt_tmo", int'(mouse_position_x), 516);
        check("t5.fe_none", fe_cnt - fe0, 0);

        // X overflow forces dx to 0, buttons still update
        send_packet(8'h4F, 8'h10, 8'h04);
        check_pos("t6.ovf", 516, 361, 7);

        // Reset in the middle of byte 2
        send_byte(8'h08);
        send_frame(8'h03, 1'b0, 5);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check_pos("t6.rst", 320, 240, 0);
        rstn = 1'b0;
        repeat (10) @(negedge clk);
        send_packet(8'h08, 8'h03, 8'h01);
        check_pos("t6.clean", 323, 239, 0);

        // Left, top and bottom clamps
        send_packet(8'h18, 8'h80, 8'h00);
        check("t7.x1", int'(mouse_position_x), 195);
        send_packet(8'h18, 8'h80, 8'h00);
        send_packet(8'h18, 8'h80, 8'h00);
        check("t7.x_lo", int'(mouse_position_x), 0);
        send_packet(8'h08, 8'h00, 8'h7F);
        check("t7.y1", int'(mouse_position_y), 112);
        send_packet(8'h08, 8'h00, 8'h7F);
        check("t7.y_top", int'(mouse_position_y), 0);
        send_packet(8'h28, 8'h00, 8'h00);
        check("t7.y256", int'(mouse_position_y), 256);
        send_packet(8'h28, 8'h00, 8'h00);
        check("t7.y_bot", int'(mouse_position_y), 479);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
